rtc_stopwatch_disp: RTL and testbench
=====================================

Name: rtc_stopwatch_disp

Overview:
Stopwatch and display stage that sits directly downstream of the push-button debouncer. It consumes the debounced button levels and edge-detects them into start/stop and clear commands. It counts elapsed time as SS.hh in four BCD digits and drives a time-multiplexed, active-low 4-digit seven-segment display.

Parameters:
TICK_DIV, 1000000, clock cycles per hundredth of a second (100 MHz clock gives 10 ms); legal values >= 2
REFRESH_BITS, 18, width of the free-running display refresh counter; the top 2 bits select the digit; legal values >= 3

Ports:
clock  input  1  system clock; all logic is on the rising edge
reset  input  1  synchronous, active-high reset
btn_ss  input  1  debounced start/stop level, active-high
btn_clr  input  1  debounced clear level, active-high
an  output  4  digit anodes, active-low one-hot; an[0] is the rightmost digit (hundredths)
seg  output  7  segment cathodes {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low
running  output  1  high while the stopwatch is counting
wrap  output  1  one-cycle pulse when the count rolls over from 59.99 to 00.00

Behaviour:
- All state is registered. Reset is synchronous and active-high, and it overrides every other event in the same cycle.
- Reset values: an=4'b1111, seg=7'h7F, dp=1, running=0, wrap=0. Digits d3..d0 reset to 0. Prescaler and refresh counter reset to 0.
- Edge detect: each button has its own previous-level register, which resets to 1. A level held high through reset release therefore produces no event.
  - A press is the cycle where the level is 1 and the previous level is 0. It takes effect on the next clock edge.
- Start/stop: a press of btn_ss toggles running.
- Clear:
  - A press of btn_clr while running=0 zeroes d3..d0 and the prescaler.
  - A press of btn_clr while running=1 is ignored.
- Simultaneous presses while stopped: clear wins and the btn_ss press is discarded, so running stays 0. Simultaneous presses while running: the btn_ss press stops the count and the clear is ignored.
- Prescaler: counts 0..TICK_DIV-1 only while running=1.
  - It holds its value while stopped, so resume continues mid-interval.
  - tick is asserted when the prescaler equals TICK_DIV-1 and running=1. On tick the prescaler wraps to 0.
- BCD counter: advances only on tick.
  - d0 (hundredths) and d1 (tenths) count 0-9. d2 (seconds units) counts 0-9. d3 (seconds tens) counts 0-5.
  - Each digit carries into the next on wrap to 0.
  - 59.99 + tick gives 00.00, with wrap=1 for exactly that cycle. running is unaffected by the rollover.
- Display mux: the refresh counter free-runs (including while stopped) and wraps modulo 2^REFRESH_BITS.
  - sel = refresh[REFRESH_BITS-1:REFRESH_BITS-2]. sel=0..3 selects digits d0..d3 respectively.
  - an, seg and dp are registered with 1-cycle latency from sel and the digit values.
  - an = ~(1<<sel).
  - dp is 0 only when sel=2, so the point sits after the seconds digit. Otherwise dp is 1.
  - seg decodes BCD 0-9 with the standard pattern: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - Any other nibble (unreachable) decodes to 7'h7F (blank).
- Reset mid-count returns everything to the reset values within one cycle. The first refreshed digit after reset shows 0.

Optional Feature:
Macro RTC_LAP_EN.
- Defined:
  - Adds input port btn_lap (1 bit, debounced, active-high), with the same edge detect as the other buttons.
  - A press while running=1 toggles freeze. On entry to freeze, d3..d0 are snapshotted. While frozen, the display shows the snapshot and counting continues underneath.
  - A press while running=0 is ignored. Stopping does not release freeze.
  - An accepted clear releases freeze. freeze resets to 0.
- Undefined: the port and the freeze logic are absent, and the display always shows the live digits.

Test Plan:
All scenarios use TICK_DIV=4 and REFRESH_BITS=4.
1. Reset for 2 cycles, then idle for 20 cycles -> an cycles 1110, 1101, 1011, 0111, each for 4 cycles; seg=7'h40 on every digit; dp=0 only while an=1011; running=0.
2. btn_ss held high through reset release -> no start and running stays 0. Then drop btn_ss for 1 cycle and raise it -> running=1 two edges after the rise. After 40 cycles the digits read 00.10.
3. Run for 23 ticks, press btn_ss -> digits freeze at 00.23 and the prescaler holds. Press btn_ss again -> the next tick arrives after the remaining prescaler cycles, not after a full 4 cycles.
4. While running, press btn_clr -> no change. Stop, then press btn_clr and btn_ss in the same cycle -> digits 00.00 and running=0.
5. Preload by running to 59.98, then apply 2 ticks -> 59.99 then 00.00; wrap is high for exactly 1 cycle coinciding with 00.00; running stays 1.
6. With RTC_LAP_EN defined: at 00.05, press btn_lap -> display holds 00.05 while the count continues to 00.20. Press btn_lap -> display shows live 00.20+. Freeze again, stop, press btn_clr -> freeze released and the display shows 00.00.

Source files
------------

// File: rtl/rtc_stopwatch_disp_if.sv
// Button inputs and multiplexed display outputs of the stopwatch stage.
// btn_lap exists only when RTC_LAP_EN is defined.
interface rtc_stopwatch_disp_if;
   logic       btn_ss;
   logic       btn_clr;
`ifdef RTC_LAP_EN
   logic       btn_lap;
`endif
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       running;
   logic       wrap;

   modport master (
      output btn_ss,
      output btn_clr,
`ifdef RTC_LAP_EN
      output btn_lap,
`endif
      input  an,
      input  seg,
      input  dp,
      input  running,
      input  wrap
   );

   modport slave (
      input  btn_ss,
      input  btn_clr,
`ifdef RTC_LAP_EN
      input  btn_lap,
`endif
      output an,
      output seg,
      output dp,
      output running,
      output wrap
   );
endinterface

// File: rtl/rtc_stopwatch_disp.sv
// SS.hh BCD stopwatch with muxed active-low 4-digit seven-segment display.
// Optional lap freeze of the displayed value under macro RTC_LAP_EN.
module rtc_stopwatch_disp #(
   parameter int TICK_DIV     = 1000000,
   parameter int REFRESH_BITS = 18
) (
   input logic                 clock,
   input logic                 reset,
   rtc_stopwatch_disp_if.slave io
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic                    prev_ss, prev_clr;
   logic                    hit_ss, hit_clr;
   logic                    running_q, wrap_q;
   logic [PW-1:0]           presc;
   logic [3:0]              d0, d1, d2, d3;
   logic [REFRESH_BITS-1:0] refresh;
   logic [3:0]              an_q;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q;
   logic                    tick, clr_ok, at_max;
   logic [1:0]              sel;
   logic [15:0]             shown;
   logic [3:0]              nib;

   always_comb begin
      tick   = running_q && (presc == LAST);
      clr_ok = hit_clr && !running_q;
      at_max = (d3 == 4'd5) && (d2 == 4'd9) &&
               (d1 == 4'd9) && (d0 == 4'd9);
      sel    = refresh[REFRESH_BITS-1 -: 2];
   end

   // Previous levels reset high so a button held through reset is not a press.
   always_ff @(posedge clock) begin
      if (reset) begin
         prev_ss  <= 1'b1;
         prev_clr <= 1'b1;
         hit_ss   <= 1'b0;
         hit_clr  <= 1'b0;
      end else begin
         prev_ss  <= io.btn_ss;
         prev_clr <= io.btn_clr;
         hit_ss   <= io.btn_ss & ~prev_ss;
         hit_clr  <= io.btn_clr & ~prev_clr;
      end
   end

   always_ff @(posedge clock) begin
      if (reset)
         running_q <= 1'b0;
      else if (hit_ss && !clr_ok)
         running_q <= !running_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         presc  <= '0;
         wrap_q <= 1'b0;
         d0     <= 4'd0;
         d1     <= 4'd0;
         d2     <= 4'd0;
         d3     <= 4'd0;
      end else begin
         wrap_q <= tick && at_max;
         if (clr_ok) begin
            presc <= '0;
            d0    <= 4'd0;
            d1    <= 4'd0;
            d2    <= 4'd0;
            d3    <= 4'd0;
         end else if (tick) begin
            presc <= '0;
            if (d0 != 4'd9) begin
               d0 <= d0 + 4'd1;
            end else begin
               d0 <= 4'd0;
               if (d1 != 4'd9) begin
                  d1 <= d1 + 4'd1;
               end else begin
                  d1 <= 4'd0;
                  if (d2 != 4'd9) begin
                     d2 <= d2 + 4'd1;
                  end else begin
                     d2 <= 4'd0;
                     d3 <= (d3 == 4'd5) ? 4'd0 : d3 + 4'd1;
                  end
               end
            end
         end else if (running_q) begin
            presc <= presc + 1'b1;
         end
      end
   end

`ifdef RTC_LAP_EN
   logic        prev_lap, hit_lap, freeze;
   logic [15:0] snap;

   always_ff @(posedge clock) begin
      if (reset) begin
         prev_lap <= 1'b1;
         hit_lap  <= 1'b0;
         freeze   <= 1'b0;
         snap     <= '0;
      end else begin
         prev_lap <= io.btn_lap;
         hit_lap  <= io.btn_lap & ~prev_lap;
         if (clr_ok) begin
            freeze <= 1'b0;
         end else if (hit_lap && running_q) begin
            freeze <= !freeze;
            if (!freeze)
               snap <= {d3, d2, d1, d0};
         end
      end
   end

   assign shown = freeze ? snap : {d3, d2, d1, d0};
`else
   assign shown = {d3, d2, d1, d0};
`endif

   always_comb begin
      nib   = shown[{sel, 2'b00} +: 4];
      seg_d = 7'h7F;
      unique case (nib)
         4'd0:    seg_d = 7'h40;
         4'd1:    seg_d = 7'h79;
         4'd2:    seg_d = 7'h24;
         4'd3:    seg_d = 7'h30;
         4'd4:    seg_d = 7'h19;
         4'd5:    seg_d = 7'h12;
         4'd6:    seg_d = 7'h02;
         4'd7:    seg_d = 7'h78;
         4'd8:    seg_d = 7'h00;
         4'd9:    seg_d = 7'h10;
         default: seg_d = 7'h7F;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         refresh <= '0;
         an_q    <= 4'b1111;
         seg_q   <= 7'h7F;
         dp_q    <= 1'b1;
      end else begin
         refresh <= refresh + 1'b1;
         an_q    <= ~(4'b0001 << sel);
         seg_q   <= seg_d;
         dp_q    <= (sel != 2'd2);
      end
   end

   assign io.an      = an_q;
   assign io.seg     = seg_q;
   assign io.dp      = dp_q;
   assign io.running = running_q;
   assign io.wrap    = wrap_q;

endmodule

// File: tb/tb_rtc_stopwatch_disp.sv
// Directed scoreboard bench for rtc_stopwatch_disp (TICK_DIV=4, REFRESH_BITS=4).
// Lap steps run only when RTC_LAP_EN is defined.
module tb_rtc_stopwatch_disp;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   logic clock = 1'b0;
   logic reset;
   exp_t sb[$];
   int   n_asrt = 0;
   int   n_fail = 0;
   int   wrap_seen = 0;

   rtc_stopwatch_disp_if io ();

   rtc_stopwatch_disp #(
      .TICK_DIV     (4),
      .REFRESH_BITS (4)
   ) dut (
      .clock (clock),
      .reset (reset),
      .io    (io)
   );

   always #5 clock = ~clock;

   always @(negedge clock)
      if (reset === 1'b0 && io.wrap === 1'b1)
         wrap_seen++;

   task automatic push(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic chk(input logic [31:0] obs);
      exp_t e;
      n_asrt++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty observed=%0h", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h",
                   e.tag, obs, e.val);
         end
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic pulse(input logic ss, input logic clr);
      io.btn_ss  = ss;
      io.btn_clr = clr;
      cyc(1);
      io.btn_ss  = 1'b0;
      io.btn_clr = 1'b0;
      cyc(1);
   endtask

`ifdef RTC_LAP_EN
   task automatic pulse_lap();
      io.btn_lap = 1'b1;
      cyc(1);
      io.btn_lap = 1'b0;
      cyc(1);
   endtask
`endif

   function automatic logic [3:0] seg2bcd(input logic [6:0] s);
      case (s)
         7'h40:   return 4'd0;
         7'h79:   return 4'd1;
         7'h24:   return 4'd2;
         7'h30:   return 4'd3;
         7'h19:   return 4'd4;
         7'h12:   return 4'd5;
         7'h02:   return 4'd6;
         7'h78:   return 4'd7;
         7'h00:   return 4'd8;
         7'h10:   return 4'd9;
         default: return 4'hF;
      endcase
   endfunction

   // One full refresh period, digits rebuilt from the anode/segment pattern.
   task automatic read_disp(output logic [15:0] v);
      v = 'x;
      repeat (16) begin
         @(negedge clock);
         case (io.an)
            4'b1110: v[3:0]   = seg2bcd(io.seg);
            4'b1101: v[7:4]   = seg2bcd(io.seg);
            4'b1011: v[11:8]  = seg2bcd(io.seg);
            4'b0111: v[15:12] = seg2bcd(io.seg);
            default: ;
         endcase
      end
      @(posedge clock);
      #1;
   endtask

   task automatic disp_chk(input string tag, input logic [15:0] e);
      logic [15:0] v;
      push(tag, {16'd0, e});
      read_disp(v);
      chk({16'd0, v});
   endtask

   initial begin
      int         sel;
      logic [3:0] an_e;
      int         wcnt;
      int         wat;

      reset      = 1'b1;
      io.btn_ss  = 1'b0;
      io.btn_clr = 1'b0;
`ifdef RTC_LAP_EN
      io.btn_lap = 1'b0;
`endif
      cyc(2);
      push("reset_state", {18'd0, 4'b1111, 7'h7F, 3'b100});
      chk({18'd0, io.an, io.seg, io.dp, io.running, io.wrap});
      reset = 1'b0;

      for (int k = 1; k <= 20; k++) begin
         sel  = ((k - 1) / 4) % 4;
         an_e = 4'b1111 ^ (4'b0001 << sel);
         push($sformatf("idle%0d", k),
              {19'd0, an_e, 7'h40, (sel != 2), 1'b0});
         cyc(1);
         chk({19'd0, io.an, io.seg, io.dp, io.running});
      end

      reset     = 1'b1;
      io.btn_ss = 1'b1;
      cyc(2);
      reset = 1'b0;
      cyc(3);
      push("held_ss_no_start", 32'd0);
      chk({31'd0, io.running});
      io.btn_ss = 1'b0;
      cyc(1);
      io.btn_ss = 1'b1;
      cyc(1);
      push("start_edge1", 32'd0);
      chk({31'd0, io.running});
      cyc(1);
      push("start_edge2", 32'd1);
      chk({31'd0, io.running});
      io.btn_ss = 1'b0;
      cyc(38);
      pulse(1'b1, 1'b0);
      push("stopped", 32'd0);
      chk({31'd0, io.running});
      disp_chk("ten_ticks", 16'h0010);

      pulse(1'b0, 1'b1);
      disp_chk("clear_stopped", 16'h0000);
      pulse(1'b1, 1'b0);
      cyc(92);
      pulse(1'b1, 1'b0);
      disp_chk("ticks23", 16'h0023);
      pulse(1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      disp_chk("resume_midinterval", 16'h0024);

      pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
      pulse(1'b1, 1'b0);
      disp_chk("clr_while_running", 16'h0025);
      pulse(1'b1, 1'b1);
      push("both_running", 32'd0);
      chk({31'd0, io.running});
      disp_chk("both_clear_wins", 16'h0000);

      pulse(1'b1, 1'b0);
      cyc(10);
      reset = 1'b1;
      cyc(1);
      push("midrun_reset", {18'd0, 4'b1111, 7'h7F, 3'b100});
      chk({18'd0, io.an, io.seg, io.dp, io.running, io.wrap});
      reset = 1'b0;
      disp_chk("after_reset", 16'h0000);

      pulse(1'b1, 1'b0);
      cyc(23994);
      pulse(1'b1, 1'b0);
      disp_chk("preload_5999", 16'h5999);
      push("no_early_wrap", 32'd0);
      chk(wrap_seen);
      pulse(1'b1, 1'b0);
      wcnt = 0;
      wat  = 0;
      for (int i = 1; i <= 12; i++) begin
         cyc(1);
         if (io.wrap === 1'b1) begin
            wcnt++;
            if (wat == 0)
               wat = i;
         end
      end
      push("wrap_pulses", 32'd1);
      chk(wcnt);
      push("wrap_cycle", 32'd4);
      chk(wat);
      push("run_after_wrap", 32'd1);
      chk({31'd0, io.running});
      pulse(1'b1, 1'b0);
      disp_chk("after_wrap", 16'h0002);

`ifdef RTC_LAP_EN
      pulse(1'b0, 1'b1);
      pulse(1'b1, 1'b0);
      cyc(20);
      pulse_lap();
      disp_chk("lap_hold", 16'h0005);
      pulse_lap();
      cyc(38);
      pulse(1'b1, 1'b0);
      disp_chk("lap_live", 16'h0020);
      pulse(1'b1, 1'b0);
      pulse_lap();
      pulse(1'b1, 1'b0);
      disp_chk("lap_after_stop", 16'h0020);
      pulse(1'b0, 1'b1);
      disp_chk("lap_cleared", 16'h0000);
`endif

      push("wrap_total", 32'd1);
      chk(wrap_seen);
      push("sb_drained", 32'd0);
      chk(sb.size() - 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_asrt, n_fail);
      $finish;
   end

endmodule
